// File: rtl/uart_fifo_ctrl_if.sv
// Handshake bundle between the UART byte FIFO and its producer/consumer.
// The master modport drives requests; the slave modport is the FIFO itself.
interface uart_fifo_ctrl_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              en;
    logic              flush;
    logic              enqueue;
    logic [WIDTH-1:0]  enqueue_data;
    logic              dequeue;
    logic              clear_err;
    logic [WIDTH-1:0]  queue_head_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              almost_full;
    logic              almost_empty;
    logic              overflow;
    logic              underflow;
    logic [ADDR_W:0]   high_water;

    modport master (
        output en, flush, enqueue, enqueue_data, dequeue, clear_err,
        input  queue_head_data, empty, full, count, almost_full, almost_empty,
               overflow, underflow, high_water
    );

    modport slave (
        input  en, flush, enqueue, enqueue_data, dequeue, clear_err,
        output queue_head_data, empty, full, count, almost_full, almost_empty,
               overflow, underflow, high_water
    );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// Parametrised first-word-fall-through byte queue with occupancy, threshold flags,
// sticky error bits, flush and a high-water mark.
module uart_fifo_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = (1 << ADDR_W) - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic             clk,
    input logic             rst,
    uart_fifo_ctrl_if.slave bus
);
    localparam int unsigned     DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AfCnt    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AeCnt    = (ADDR_W + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] rear_q, rear_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   hw_q, hw_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              is_empty, is_full;
    logic              wr_ok, rd_ok, clr;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DepthCnt);
    assign clr      = bus.flush | ~bus.en;

    // A full queue still accepts a write when the head is popped in the same cycle.
    assign wr_ok = bus.enqueue & (~is_full | bus.dequeue);
    assign rd_ok = bus.dequeue & ~is_empty;

    always_comb begin
        head_d  = head_q;
        rear_d  = rear_q;
        count_d = count_q;
        hw_d    = hw_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (bus.clear_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (clr) begin
            head_d  = '0;
            rear_d  = '0;
            count_d = '0;
            hw_d    = '0;
        end else begin
            if (wr_ok) begin
                rear_d = rear_q + 1'b1;
            end
            if (rd_ok) begin
                head_d = head_q + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - 1'b1;
            end
            hw_d = (count_d > hw_q) ? count_d : hw_q;
            // A new error outranks a same-cycle clear.
            if (bus.enqueue && !wr_ok) begin
                ovf_d = 1'b1;
            end
            if (bus.dequeue && !rd_ok) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            rear_q  <= '0;
            count_q <= '0;
            hw_q    <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            hw_q    <= hw_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && !clr && wr_ok) begin
            mem_q[rear_q] <= bus.enqueue_data;
        end
    end

    assign bus.queue_head_data = mem_q[head_q];
    assign bus.empty           = is_empty;
    assign bus.full            = is_full;
    assign bus.count           = count_q;
    assign bus.almost_full     = (count_q >= AfCnt);
    assign bus.almost_empty    = (count_q <= AeCnt);
    assign bus.overflow        = ovf_q;
    assign bus.underflow       = udf_q;
    assign bus.high_water      = hw_q;
endmodule
